// File: rtl/perf_pkg.sv
// perf_pkg -- shared definitions for the performance counter unit.
//   state_t     : FSM state type with fixed encodings (observable on state_o)
//   DEF_CNT_W   : default counter width
//   DEF_NUM_CH  : default number of event channels
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_NUM_CH = 4;

endpackage

// File: rtl/perf_chan.sv
// perf_chan -- one event counter with a sticky overflow flag.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-low reset
//   clear_i  synchronous clear of the count and the overflow flag
//   inc_i    add one to the count on this edge
//   count_o  current count (CNT_W bits)
//   ovf_o    sticky overflow flag, set when incrementing from all-ones
// SATURATE=1 holds the count at all-ones on overflow, SATURATE=0 wraps to zero.
module perf_chan #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
      ovf_o   <= 1'b0;
    end else if (clear_i) begin
      count_o <= '0;
      ovf_o   <= 1'b0;
    end else if (inc_i) begin
      if (&count_o) begin
        // Incrementing from all-ones: flag it, then hold or wrap.
        ovf_o   <= 1'b1;
        count_o <= SATURATE ? count_o : '0;
      end else begin
        count_o <= count_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit -- multi-channel performance counter with a cycle
// counter, optional cycle limit and a small run-control FSM.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-low reset
//   start_i   level, requests counting
//   clear_i   synchronous clear of counters, cycle count and flags
//   freeze_i  level, pauses counting while keeping values
//   event_i   one event pulse bit per channel
//   limit_i   cycle limit, 0 means unlimited
//   sel_i     channel read select
//   count_o   registered value of the selected channel (0 if out of range)
//   cycle_o   number of counted RUN cycles
//   ovf_o     sticky per-channel overflow flags
//   state_o   current FSM state
//   done_o    high while in DONE
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = 1'b0,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              freeze_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [CNT_W-1:0]  limit_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic [NUM_CH-1:0] ovf_o,
  output logic [1:0]        state_o,
  output logic              done_o
);

  state_t           state, state_nxt;
  logic             count_en;
  logic             limit_hit;
  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W-1:0] sel_val;
  logic [CNT_W-1:0] chan_cnt [NUM_CH];

  // Counting only happens on an edge that stays in the running condition:
  // freeze_i or a dropped start_i pause the edge that leaves RUN, and clear wins.
  assign count_en  = (state == ST_RUN) && start_i && !freeze_i && !clear_i;
  assign cycle_inc = cycle_o + {{(CNT_W-1){1'b0}}, 1'b1};
  assign limit_hit = count_en && (limit_i != '0) && (cycle_inc == limit_i);

  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = ST_IDLE;
    end else if (limit_hit) begin
      state_nxt = ST_DONE;
    end else begin
      case (state)
        ST_IDLE:   if (start_i) state_nxt = ST_RUN;
        ST_RUN: begin
          if (freeze_i)      state_nxt = ST_FROZEN;
          else if (!start_i) state_nxt = ST_IDLE;
        end
        ST_FROZEN: if (!freeze_i) state_nxt = start_i ? ST_RUN : ST_IDLE;
        ST_DONE:   state_nxt = ST_DONE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_o <= '0;
    end else if (clear_i) begin
      cycle_o <= '0;
    end else if (count_en) begin
      // Same overflow rule as the channels, but without a flag.
      if (!(SATURATE && (&cycle_o))) cycle_o <= cycle_inc;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    perf_chan #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .inc_i   (count_en && event_i[k]),
      .count_o (chan_cnt[k]),
      .ovf_o   (ovf_o[k])
    );
  end

  always_comb begin
    sel_val = '0;
    if (int'(sel_i) < NUM_CH) sel_val = chan_cnt[sel_i];
  end

  // Read port samples the counter value before this edge's update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       count_o <= '0;
    else if (clear_i) count_o <= '0;
    else              count_o <= sel_val;
  end

  assign state_o = state;
  assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit -- directed bench for perf_counter_unit. Two
// instances (wrapping and saturating, 8-bit counters, 3 channels) share one
// set of inputs and are compared every cycle against a behavioural model.
module tb_perf_counter_unit;

  localparam int NCH    = 3;
  localparam int MAXV   = 255;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_FRZ  = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear, freeze;
  logic [2:0] ev;
  logic [7:0] lim;
  logic [1:0] sel;

  logic [7:0] count_w [2];
  logic [7:0] cycle_w [2];
  logic [2:0] ovf_w   [2];
  logic [1:0] state_w [2];
  logic       done_w  [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: index 0 = wrapping instance, index 1 = saturating instance.
  int       m_state [2];
  int       m_cyc   [2];
  int       m_out   [2];
  int       m_cnt   [2][NCH];
  bit [2:0] m_ovf   [2];

  perf_counter_unit #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
    .freeze_i(freeze), .event_i(ev), .limit_i(lim), .sel_i(sel),
    .count_o(count_w[0]), .cycle_o(cycle_w[0]), .ovf_o(ovf_w[0]),
    .state_o(state_w[0]), .done_o(done_w[0])
  );

  perf_counter_unit #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear),
    .freeze_i(freeze), .event_i(ev), .limit_i(lim), .sel_i(sel),
    .count_o(count_w[1]), .cycle_o(cycle_w[1]), .ovf_o(ovf_w[1]),
    .state_o(state_w[1]), .done_o(done_w[1])
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; they are seen by exactly one rising edge.
  task automatic applyStimulus(input logic st, input logic cl, input logic fr,
                               input logic [2:0] e, input logic [7:0] l, input logic [1:0] s);
    start  = st;
    clear  = cl;
    freeze = fr;
    ev     = e;
    lim    = l;
    sel    = s;
    @(negedge clk);
  endtask

  // Behavioural model of the counting rules.
  always @(posedge clk or negedge rst_n) begin : model
    int nv;
    bit go;
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        m_state[s] <= M_IDLE;
        m_cyc[s]   <= 0;
        m_out[s]   <= 0;
        m_ovf[s]   <= 3'b000;
        for (int k = 0; k < NCH; k++) m_cnt[s][k] <= 0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        go = (m_state[s] == M_RUN) && start && !freeze && !clear;
        if (clear) begin
          m_state[s] <= M_IDLE;
          m_cyc[s]   <= 0;
          m_out[s]   <= 0;
          m_ovf[s]   <= 3'b000;
          for (int k = 0; k < NCH; k++) m_cnt[s][k] <= 0;
        end else begin
          m_out[s] <= (int'(sel) < NCH) ? m_cnt[s][sel] : 0;
          if (go) begin
            nv = m_cyc[s] + 1;
            if (nv > MAXV) nv = (s == 1) ? MAXV : 0;
            m_cyc[s] <= nv;
            for (int k = 0; k < NCH; k++) begin
              if (ev[k]) begin
                nv = m_cnt[s][k] + 1;
                if (nv > MAXV) begin
                  m_ovf[s][k] <= 1'b1;
                  nv = (s == 1) ? MAXV : 0;
                end
                m_cnt[s][k] <= nv;
              end
            end
          end
          if (go && lim != 0 && ((m_cyc[s] + 1) % (MAXV + 1)) == int'(lim))
            m_state[s] <= M_DONE;
          else if (m_state[s] == M_IDLE && start)
            m_state[s] <= M_RUN;
          else if (m_state[s] == M_RUN && freeze)
            m_state[s] <= M_FRZ;
          else if (m_state[s] == M_RUN && !start)
            m_state[s] <= M_IDLE;
          else if (m_state[s] == M_FRZ && !freeze)
            m_state[s] <= start ? M_RUN : M_IDLE;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int s = 0; s < 2; s++) begin
        checkOutput($sformatf("state[%0d]", s), 64'(state_w[s]), 64'(m_state[s]));
        checkOutput($sformatf("done[%0d]", s),  64'(done_w[s]),  64'(m_state[s] == M_DONE));
        checkOutput($sformatf("cycle[%0d]", s), 64'(cycle_w[s]), 64'(m_cyc[s]));
        checkOutput($sformatf("count[%0d]", s), 64'(count_w[s]), 64'(m_out[s]));
        checkOutput($sformatf("ovf[%0d]", s),   64'(ovf_w[s]),   64'(m_ovf[s]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; clear = 1'b0; freeze = 1'b0;
    ev = 3'b000; lim = 8'd0; sel = 2'd0;
    @(negedge clk);
    cmp_en = 1'b1;
    checkOutput("rst_state", 64'(state_w[0]), 64'd0);
    checkOutput("rst_cycle", 64'(cycle_w[0]), 64'd0);
    checkOutput("rst_count", 64'(count_w[0]), 64'd0);
    checkOutput("rst_ovf",   64'(ovf_w[0]),   64'd0);
    checkOutput("rst_done",  64'(done_w[0]),  64'd0);
    rst_n = 1'b1;

    // 7 events in 10 run cycles, unlimited.
    applyStimulus(1, 0, 0, 3'b000, 8'd0, 2'd0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 0, (i == 2 || i == 5 || i == 8) ? 3'b000 : 3'b001, 8'd0, 2'd0);
    applyStimulus(0, 0, 0, 3'b000, 8'd0, 2'd0);
    checkOutput("basic_count", 64'(count_w[0]), 64'd7);
    checkOutput("basic_cycle", 64'(cycle_w[0]), 64'd10);
    checkOutput("basic_idle",  64'(state_w[0]), 64'd0);

    // Limit of 30 cycles with channel 1 firing every cycle.
    applyStimulus(0, 1, 0, 3'b000, 8'd0, 2'd1);
    applyStimulus(1, 0, 0, 3'b010, 8'd30, 2'd1);
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, 0, 3'b010, 8'd30, 2'd1);
    checkOutput("limit_done",  64'(done_w[0]),  64'd1);
    checkOutput("limit_cycle", 64'(cycle_w[0]), 64'd30);
    checkOutput("limit_state", 64'(state_w[0]), 64'd3);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 3'b010, 8'd30, 2'd1);
    checkOutput("hold_done",  64'(done_w[0]),  64'd1);
    checkOutput("hold_cycle", 64'(cycle_w[0]), 64'd30);
    checkOutput("hold_ch1",   64'(count_w[0]), 64'd30);

    // Clear and limit match on the same edge.
    applyStimulus(0, 1, 0, 3'b000, 8'd0, 2'd0);
    applyStimulus(1, 0, 0, 3'b001, 8'd3, 2'd0);
    applyStimulus(1, 0, 0, 3'b001, 8'd3, 2'd0);
    applyStimulus(1, 0, 0, 3'b001, 8'd3, 2'd0);
    applyStimulus(1, 1, 0, 3'b001, 8'd3, 2'd0);
    checkOutput("clrlim_state", 64'(state_w[0]), 64'd0);
    checkOutput("clrlim_done",  64'(done_w[0]),  64'd0);
    checkOutput("clrlim_cycle", 64'(cycle_w[0]), 64'd0);
    checkOutput("clrlim_count", 64'(count_w[0]), 64'd0);

    // 257 events on channel 2: wrap vs saturate.
    applyStimulus(1, 0, 0, 3'b100, 8'd0, 2'd2);
    for (int i = 0; i < 257; i++) applyStimulus(1, 0, 0, 3'b100, 8'd0, 2'd2);
    applyStimulus(0, 0, 0, 3'b000, 8'd0, 2'd2);
    checkOutput("wrap_ch2",   64'(count_w[0]), 64'd1);
    checkOutput("wrap_ovf",   64'(ovf_w[0]),   64'd4);
    checkOutput("wrap_cycle", 64'(cycle_w[0]), 64'd1);
    checkOutput("sat_ch2",    64'(count_w[1]), 64'd255);
    checkOutput("sat_ovf",    64'(ovf_w[1]),   64'd4);
    checkOutput("sat_cycle",  64'(cycle_w[1]), 64'd255);

    // Freeze for 4 cycles with events present.
    applyStimulus(0, 1, 0, 3'b000, 8'd0, 2'd0);
    applyStimulus(1, 0, 0, 3'b000, 8'd0, 2'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 3'b001, 8'd0, 2'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 3'b001, 8'd0, 2'd0);
    applyStimulus(1, 0, 0, 3'b000, 8'd0, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 3'b001, 8'd0, 2'd0);
    applyStimulus(0, 0, 0, 3'b000, 8'd0, 2'd0);
    checkOutput("freeze_count", 64'(count_w[0]), 64'd8);
    checkOutput("freeze_cycle", 64'(cycle_w[0]), 64'd8);
    applyStimulus(0, 0, 0, 3'b000, 8'd0, 2'd3);
    checkOutput("sel_oob", 64'(count_w[0]), 64'd0);

    // Limit lowered below the current cycle count, then async reset mid-run.
    applyStimulus(0, 1, 0, 3'b000, 8'd0, 2'd0);
    applyStimulus(1, 0, 0, 3'b011, 8'd0, 2'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 3'b011, 8'd0, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 3'b011, 8'd3, 2'd0);
    checkOutput("lowlim_run",   64'(state_w[0]), 64'd1);
    checkOutput("lowlim_cycle", 64'(cycle_w[0]), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_state", 64'(state_w[0]), 64'd0);
    checkOutput("arst_cycle", 64'(cycle_w[0]), 64'd0);
    checkOutput("arst_count", 64'(count_w[0]), 64'd0);
    checkOutput("arst_ovf",   64'(ovf_w[1]),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 3'b001, 8'd0, 2'd0);
    checkOutput("resume_state", 64'(state_w[0]), 64'd1);
    checkOutput("resume_cycle", 64'(cycle_w[0]), 64'd2);
    applyStimulus(0, 0, 0, 3'b000, 8'd0, 2'd0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
